// File: rtl/stream_return_fifo.sv
// stream_return_fifo: multi-entry ready/valid elastic buffer for the return path.
// up_ready comes from registered state only; down_* come from storage.
// Optional feature: define STREAM_RETURN_FIFO_BYPASS_EN so that a word offered
// to an empty FIFO is presented on down_* in the same cycle.
// Logging: define LOG(msg) (e.g. as `$display msg`) to print pushes and pops,
// each prefixed with NAME; by default LOG expands to nothing.

`ifndef LOG
`define LOG(msg)
`endif

module stream_return_fifo #(
  parameter int    WIDTH = 32,
  parameter int    DEPTH = 4,
  parameter string NAME  = "fifo"
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       up_valid,
  output logic                       up_ready,
  input  logic [WIDTH-1:0]           up_data,
  output logic                       down_valid,
  input  logic                       down_ready,
  output logic [WIDTH-1:0]           down_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // A single-entry FIFO cannot overlap a push with a pop at full, so refuse it.
  if (DEPTH < 2) begin : g_depth_check
    $error("%s: DEPTH must be at least 2", NAME);
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    occ;
  logic             ready_en;
  logic             push;
  logic             pop;
  logic             bypass;

  // ready_en keeps up_ready low until the first clock after reset releases.
  assign up_ready = ready_en & (occ != FULL_CNT);
  assign count    = occ;

`ifdef STREAM_RETURN_FIFO_BYPASS_EN
  // An empty FIFO forwards the offered word directly; when it is taken in the
  // same cycle, nothing is stored and the pointers stay put.
  assign bypass     = ready_en & (occ == '0) & up_valid & down_ready;
  assign down_valid = (occ != '0) | (ready_en & up_valid);
  assign down_data  = (occ == '0) ? up_data : mem[rd_ptr];
`else
  assign bypass     = 1'b0;
  assign down_valid = (occ != '0);
  assign down_data  = mem[rd_ptr];
`endif

  assign push = up_valid & up_ready & ~bypass;
  assign pop  = down_valid & down_ready & ~bypass;

  // Pointers and occupancy; pointers wrap with an explicit compare so any DEPTH works.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Storage is deliberately not reset; only the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= up_data;
      `LOG(("%s: push %h", NAME, up_data));
    end
    if (pop) begin
      `LOG(("%s: pop %h", NAME, down_data));
    end
  end

endmodule

// File: tb/tb_stream_return_fifo.sv
// tb_stream_return_fifo: self-checking bench for stream_return_fifo.
// Instance a uses DEPTH=4, instance b uses DEPTH=3 for the wrap test.
// Expectations follow STREAM_RETURN_FIFO_BYPASS_EN when it is defined.

module tb_stream_return_fifo;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic        a_up_valid = 1'b0;
  logic        a_up_ready;
  logic [31:0] a_up_data = '0;
  logic        a_down_valid;
  logic        a_down_ready = 1'b0;
  logic [31:0] a_down_data;
  logic [2:0]  a_count;

  logic        b_up_valid = 1'b0;
  logic        b_up_ready;
  logic [31:0] b_up_data = '0;
  logic        b_down_valid;
  logic        b_down_ready = 1'b0;
  logic [31:0] b_down_data;
  logic [1:0]  b_count;

  int n_compared = 0;
  int n_mismatched = 0;

  // Free-running clock, period 10.
  always #5 clock = ~clock;

  stream_return_fifo #(.WIDTH(32), .DEPTH(4), .NAME("fifo_a")) dut_a (
    .clock(clock), .reset(reset),
    .up_valid(a_up_valid), .up_ready(a_up_ready), .up_data(a_up_data),
    .down_valid(a_down_valid), .down_ready(a_down_ready), .down_data(a_down_data),
    .count(a_count)
  );

  stream_return_fifo #(.WIDTH(32), .DEPTH(3), .NAME("fifo_b")) dut_b (
    .clock(clock), .reset(reset),
    .up_valid(b_up_valid), .up_ready(b_up_ready), .up_data(b_up_data),
    .down_valid(b_down_valid), .down_ready(b_down_ready), .down_data(b_down_data),
    .count(b_count)
  );

  task automatic test_reset();
    repeat (2) @(negedge clock);
    #1;
    n_compared++; if (a_up_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_up_ready got %b want 0", a_up_ready); end
    n_compared++; if (a_down_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_down_valid got %b want 0", a_down_valid); end
    n_compared++; if (a_count !== 3'd0) begin n_mismatched++; $display("[TB] FAIL reset_count got %0d want 0", a_count); end
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_compared++; if (a_up_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL release_before_edge_up_ready got %b want 0", a_up_ready); end
    @(posedge clock);
    #1;
    n_compared++; if (a_up_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL release_after_edge_up_ready got %b want 1", a_up_ready); end
    n_compared++; if (b_up_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL release_b_up_ready got %b want 1", b_up_ready); end
  endtask

  task automatic test_fill();
    logic [31:0] vals [5];
    vals = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      a_up_valid = 1'b1; a_up_data = vals[k]; a_down_ready = 1'b0;
      #1;
      n_compared++; if (a_up_ready !== (k < 4)) begin n_mismatched++; $display("[TB] FAIL fill_up_ready[%0d] got %b want %b", k, a_up_ready, (k < 4)); end
    end
    @(negedge clock);
    a_up_valid = 1'b0;
    #1;
    n_compared++; if (a_count !== 3'd4) begin n_mismatched++; $display("[TB] FAIL fill_count got %0d want 4", a_count); end
    n_compared++; if (a_up_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL fill_full_up_ready got %b want 0", a_up_ready); end
    n_compared++; if (a_down_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL fill_down_valid got %b want 1", a_down_valid); end
    n_compared++; if (a_down_data !== 32'h11) begin n_mismatched++; $display("[TB] FAIL fill_head got %h want 11", a_down_data); end
  endtask

  task automatic test_drain();
    logic [31:0] vals [4];
    vals = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      a_down_ready = 1'b1;
      #1;
      n_compared++; if (a_down_data !== vals[i]) begin n_mismatched++; $display("[TB] FAIL drain_data[%0d] got %h want %h", i, a_down_data, vals[i]); end
      n_compared++; if (a_count !== 3'(4 - i)) begin n_mismatched++; $display("[TB] FAIL drain_count[%0d] got %0d want %0d", i, a_count, 4 - i); end
      n_compared++; if (a_up_ready !== (i >= 1)) begin n_mismatched++; $display("[TB] FAIL drain_up_ready[%0d] got %b want %b", i, a_up_ready, (i >= 1)); end
    end
    @(negedge clock);
    a_down_ready = 1'b0;
    #1;
    n_compared++; if (a_count !== 3'd0) begin n_mismatched++; $display("[TB] FAIL drain_end_count got %0d want 0", a_count); end
    n_compared++; if (a_down_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL drain_end_down_valid got %b want 0", a_down_valid); end
  endtask

  task automatic test_bypass();
    @(negedge clock);
    a_up_valid = 1'b1; a_up_data = 32'h5A; a_down_ready = 1'b1;
    #1;
`ifdef STREAM_RETURN_FIFO_BYPASS_EN
    n_compared++; if (a_down_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL bypass_down_valid got %b want 1", a_down_valid); end
    n_compared++; if (a_down_data !== 32'h5A) begin n_mismatched++; $display("[TB] FAIL bypass_data got %h want 5a", a_down_data); end
    @(negedge clock);
    a_up_valid = 1'b0; a_down_ready = 1'b0;
    #1;
    n_compared++; if (a_count !== 3'd0) begin n_mismatched++; $display("[TB] FAIL bypass_count got %0d want 0", a_count); end
`else
    n_compared++; if (a_down_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL nobypass_down_valid got %b want 0", a_down_valid); end
    @(negedge clock);
    a_up_valid = 1'b0; a_down_ready = 1'b0;
    #1;
    n_compared++; if (a_count !== 3'd1) begin n_mismatched++; $display("[TB] FAIL nobypass_count got %0d want 1", a_count); end
    n_compared++; if (a_down_data !== 32'h5A) begin n_mismatched++; $display("[TB] FAIL nobypass_data got %h want 5a", a_down_data); end
    @(negedge clock);
    a_down_ready = 1'b1;
    @(negedge clock);
    a_down_ready = 1'b0;
    #1;
    n_compared++; if (a_count !== 3'd0) begin n_mismatched++; $display("[TB] FAIL nobypass_drain_count got %0d want 0", a_count); end
`endif
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    a_up_valid = 1'b1; a_up_data = 32'h01; a_down_ready = 1'b0;
    @(negedge clock);
    a_up_data = 32'h02;
    @(negedge clock);
    a_up_valid = 1'b0;
    #1;
    n_compared++; if (a_count !== 3'd2) begin n_mismatched++; $display("[TB] FAIL midreset_pre_count got %0d want 2", a_count); end
    reset = 1'b1;
    #1;
    n_compared++; if (a_down_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midreset_down_valid got %b want 0", a_down_valid); end
    n_compared++; if (a_count !== 3'd0) begin n_mismatched++; $display("[TB] FAIL midreset_count got %0d want 0", a_count); end
    n_compared++; if (a_up_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midreset_up_ready got %b want 0", a_up_ready); end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    a_up_valid = 1'b1; a_up_data = 32'hAB;
    #1;
    n_compared++; if (a_up_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL midreset_release_up_ready got %b want 1", a_up_ready); end
    @(negedge clock);
    a_up_valid = 1'b0;
    #1;
    n_compared++; if (a_down_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL midreset_head_valid got %b want 1", a_down_valid); end
    n_compared++; if (a_down_data !== 32'hAB) begin n_mismatched++; $display("[TB] FAIL midreset_head got %h want ab", a_down_data); end
    n_compared++; if (a_count !== 3'd1) begin n_mismatched++; $display("[TB] FAIL midreset_head_count got %0d want 1", a_count); end
  endtask

  task automatic test_stream_wrap();
    logic [31:0] sent [10];
    logic [31:0] got [$];
    int exp_cnt;
    for (int i = 0; i < 10; i++) sent[i] = $urandom;
    for (int c = 0; c < 11; c++) begin
      @(negedge clock);
      b_up_valid = (c < 10);
      b_up_data = (c < 10) ? sent[c] : 32'h0;
      b_down_ready = 1'b1;
      #1;
      if (b_down_valid === 1'b1) got.push_back(b_down_data);
`ifdef STREAM_RETURN_FIFO_BYPASS_EN
      exp_cnt = 0;
`else
      exp_cnt = (c == 0) ? 0 : 1;
`endif
      if (c < 10) begin
        n_compared++; if (b_count !== 2'(exp_cnt)) begin n_mismatched++; $display("[TB] FAIL stream_count[%0d] got %0d want %0d", c, b_count, exp_cnt); end
      end
    end
    @(negedge clock);
    b_up_valid = 1'b0; b_down_ready = 1'b0;
    #1;
    n_compared++; if (b_count !== 2'd0) begin n_mismatched++; $display("[TB] FAIL stream_end_count got %0d want 0", b_count); end
    n_compared++; if (got.size() !== 10) begin n_mismatched++; $display("[TB] FAIL stream_received got %0d words want 10", got.size()); end
    for (int i = 0; i < 10 && i < got.size(); i++) begin
      n_compared++; if (got[i] !== sent[i]) begin n_mismatched++; $display("[TB] FAIL stream_word[%0d] got %h want %h", i, got[i], sent[i]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] q [$];
    logic        uv, dr, exp_ur, exp_dv, byp;
    logic [31:0] d, exp_d;
    q.push_back(32'hAB);
    for (int c = 0; c < 1000; c++) begin
      @(negedge clock);
      uv = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      d  = $urandom;
      a_up_valid = uv; a_down_ready = dr; a_up_data = d;
      #1;
      exp_ur = (q.size() != 4);
      byp = 1'b0;
`ifdef STREAM_RETURN_FIFO_BYPASS_EN
      byp = (q.size() == 0) && uv;
`endif
      exp_dv = (q.size() != 0) || byp;
      exp_d = (q.size() != 0) ? q[0] : d;
      n_compared++; if (a_up_ready !== exp_ur) begin n_mismatched++; $display("[TB] FAIL rand_up_ready[%0d] got %b want %b", c, a_up_ready, exp_ur); end
      n_compared++; if (a_down_valid !== exp_dv) begin n_mismatched++; $display("[TB] FAIL rand_down_valid[%0d] got %b want %b", c, a_down_valid, exp_dv); end
      n_compared++; if (a_count !== 3'(q.size())) begin n_mismatched++; $display("[TB] FAIL rand_count[%0d] got %0d want %0d", c, a_count, q.size()); end
      if (exp_dv) begin
        n_compared++; if (a_down_data !== exp_d) begin n_mismatched++; $display("[TB] FAIL rand_data[%0d] got %h want %h", c, a_down_data, exp_d); end
      end
      if (!(byp && dr)) begin
        if (exp_dv && dr) void'(q.pop_front());
        if (uv && exp_ur) q.push_back(d);
      end
    end
    @(negedge clock);
    a_up_valid = 1'b0; a_down_ready = 1'b0;
  endtask

  // Scenarios run in sequence; each one leaves instance a in a known state.
  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_bypass();
    test_reset_mid();
    test_stream_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
